// File: rtl/vga_sync_decoder.sv
// VGA timing recovery: measures Hsync_n/Vsync_n periods, locks onto stable timing and
// emits the visible pixel with its coordinates. Define VGA_DEC_STATS_EN to expose lineLen/frameLines.
//
// state  | meaning
// SEARCH | no timing reference, waiting for the first frame edge
// TRACK  | measuring frames, comparing against a captured reference
// LOCKED | timing stable, visible pixels are forwarded
module vga_sync_decoder #(
    parameter int H_SYNC_TO_ACTIVE = 184,
    parameter int H_ACTIVE         = 640,
    parameter int V_SYNC_TO_ACTIVE = 19,
    parameter int V_ACTIVE         = 480,
    parameter int LOCK_FRAMES      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Hsync_n,
    input  logic        Vsync_n,
    input  logic [2:0]  pixelIn,
    output logic [2:0]  pixelOut,
    output logic [10:0] posX,
    output logic [10:0] posY,
    output logic        active,
    output logic        frame_start,
    output logic        locked,
    output logic        err,
    output logic [10:0] lineLen,
    output logic [10:0] frameLines
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [10:0] CNT_MAX  = 11'd2047;
    localparam logic [10:0] H_START  = 11'(H_SYNC_TO_ACTIVE);
    localparam logic [10:0] H_END    = 11'(H_SYNC_TO_ACTIVE + H_ACTIVE);
    localparam logic [10:0] V_START  = 11'(V_SYNC_TO_ACTIVE);
    localparam logic [10:0] V_END    = 11'(V_SYNC_TO_ACTIVE + V_ACTIVE);
    localparam logic [7:0]  LOCK_CNT = 8'(LOCK_FRAMES);

    logic        hs1_q, hs1_d, hs2_q, hs2_d;
    logic        vs1_q, vs1_d, vs2_q, vs2_d;
    logic [2:0]  pix1_q, pix1_d;
    logic [10:0] hcnt_q, hcnt_d;
    logic [10:0] vcnt_q, vcnt_d;
    logic [10:0] line_meas_q, line_meas_d;
    logic        line_sat_q, line_sat_d;
    state_t      state_q, state_d;
    logic [10:0] ref_line_q, ref_line_d;
    logic [10:0] ref_frame_q, ref_frame_d;
    logic        ref_valid_q, ref_valid_d;
    logic [7:0]  match_cnt_q, match_cnt_d;
    logic        err_q, err_d;
    logic        locked_q, locked_d;
    logic        frame_start_q, frame_start_d;
    logic        win_q, win_d;
    logic [10:0] px_a_q, px_a_d;
    logic [10:0] py_a_q, py_a_d;
    logic        active_q, active_d;
    logic [2:0]  pix_out_q, pix_out_d;
    logic [10:0] pos_x_q, pos_x_d;
    logic [10:0] pos_y_q, pos_y_d;

    logic        h_fall, v_fall, h_sat, v_sat;
    logic [10:0] line_now, frame_now;
    logic        line_now_sat;
    logic        line_ok, frame_ok, meas_clean;

    assign h_fall = hs2_q & ~hs1_q;
    assign v_fall = vs2_q & ~vs1_q;
    assign h_sat  = (hcnt_q == CNT_MAX);
    assign v_sat  = (vcnt_q == CNT_MAX);

    // When Vsync and Hsync fall together the line just ended is the one to compare.
    assign line_now     = h_fall ? (h_sat ? CNT_MAX : hcnt_q + 11'd1) : line_meas_q;
    assign line_now_sat = h_fall ? h_sat : line_sat_q;
    assign frame_now    = v_sat ? CNT_MAX : vcnt_q + 11'd1;

    assign line_ok    = !line_now_sat && (line_now == ref_line_q);
    assign frame_ok   = !v_sat && (frame_now == ref_frame_q);
    assign meas_clean = !line_now_sat && !v_sat;

    always_comb begin
        hs1_d  = Hsync_n;
        vs1_d  = Vsync_n;
        hs2_d  = hs1_q;
        vs2_d  = vs1_q;
        pix1_d = pixelIn;

        hcnt_d = h_fall ? 11'd0 : (h_sat ? hcnt_q : hcnt_q + 11'd1);

        vcnt_d = vcnt_q;
        if (v_fall) begin
            vcnt_d = 11'd0;
        end else if (h_fall && !v_sat) begin
            vcnt_d = vcnt_q + 11'd1;
        end

        line_meas_d = line_meas_q;
        line_sat_d  = line_sat_q;
        if (h_fall) begin
            line_meas_d = line_now;
            line_sat_d  = h_sat;
        end
    end

    always_comb begin
        state_d     = state_q;
        ref_line_d  = ref_line_q;
        ref_frame_d = ref_frame_q;
        ref_valid_d = ref_valid_q;
        match_cnt_d = match_cnt_q;
        err_d       = 1'b0;

        case (state_q)
            SEARCH: begin
                if (v_fall) begin
                    state_d     = TRACK;
                    ref_valid_d = 1'b0;
                    match_cnt_d = 8'd0;
                end
            end
            TRACK: begin
                if (v_fall) begin
                    if (ref_valid_q && line_ok && frame_ok) begin
                        match_cnt_d = match_cnt_q + 8'd1;
                    end else begin
                        // The freshly captured frame is the first of the new matching run.
                        ref_line_d  = line_now;
                        ref_frame_d = frame_now;
                        ref_valid_d = meas_clean;
                        match_cnt_d = meas_clean ? 8'd1 : 8'd0;
                    end
                    if (ref_valid_d && (match_cnt_d >= LOCK_CNT)) begin
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if ((h_fall && !line_ok) || (v_fall && !frame_ok)) begin
                    err_d       = 1'b1;
                    state_d     = SEARCH;
                    ref_valid_d = 1'b0;
                    match_cnt_d = 8'd0;
                end
            end
            default: begin
                state_d     = SEARCH;
                ref_valid_d = 1'b0;
                match_cnt_d = 8'd0;
            end
        endcase

        locked_d      = (state_d == LOCKED);
        frame_start_d = v_fall;
    end

    always_comb begin
        win_d = (state_q == LOCKED) &&
                (hcnt_q >= H_START) && (hcnt_q < H_END) &&
                (vcnt_q >= V_START) && (vcnt_q < V_END);
        px_a_d = hcnt_q - H_START;
        py_a_d = vcnt_q - V_START;

        active_d  = win_q;
        pix_out_d = win_q ? pix1_q : 3'd0;
        pos_x_d   = win_q ? px_a_q : 11'd0;
        pos_y_d   = win_q ? py_a_q : 11'd0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hs1_q         <= 1'b1;
            hs2_q         <= 1'b1;
            vs1_q         <= 1'b1;
            vs2_q         <= 1'b1;
            pix1_q        <= 3'd0;
            hcnt_q        <= 11'd0;
            vcnt_q        <= 11'd0;
            line_meas_q   <= 11'd0;
            line_sat_q    <= 1'b0;
            state_q       <= SEARCH;
            ref_line_q    <= 11'd0;
            ref_frame_q   <= 11'd0;
            ref_valid_q   <= 1'b0;
            match_cnt_q   <= 8'd0;
            err_q         <= 1'b0;
            locked_q      <= 1'b0;
            frame_start_q <= 1'b0;
            win_q         <= 1'b0;
            px_a_q        <= 11'd0;
            py_a_q        <= 11'd0;
            active_q      <= 1'b0;
            pix_out_q     <= 3'd0;
            pos_x_q       <= 11'd0;
            pos_y_q       <= 11'd0;
        end else begin
            hs1_q         <= hs1_d;
            hs2_q         <= hs2_d;
            vs1_q         <= vs1_d;
            vs2_q         <= vs2_d;
            pix1_q        <= pix1_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            line_meas_q   <= line_meas_d;
            line_sat_q    <= line_sat_d;
            state_q       <= state_d;
            ref_line_q    <= ref_line_d;
            ref_frame_q   <= ref_frame_d;
            ref_valid_q   <= ref_valid_d;
            match_cnt_q   <= match_cnt_d;
            err_q         <= err_d;
            locked_q      <= locked_d;
            frame_start_q <= frame_start_d;
            win_q         <= win_d;
            px_a_q        <= px_a_d;
            py_a_q        <= py_a_d;
            active_q      <= active_d;
            pix_out_q     <= pix_out_d;
            pos_x_q       <= pos_x_d;
            pos_y_q       <= pos_y_d;
        end
    end

`ifdef VGA_DEC_STATS_EN
    logic [10:0] line_len_q, line_len_d;
    logic [10:0] frame_lines_q, frame_lines_d;

    always_comb begin
        line_len_d    = line_len_q;
        frame_lines_d = frame_lines_q;
        if (v_fall) begin
            line_len_d    = line_now;
            frame_lines_d = frame_now;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_len_q    <= 11'd0;
            frame_lines_q <= 11'd0;
        end else begin
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
        end
    end

    assign lineLen    = line_len_q;
    assign frameLines = frame_lines_q;
`else
    assign lineLen    = 11'd0;
    assign frameLines = 11'd0;
`endif

    assign pixelOut    = pix_out_q;
    assign posX        = pos_x_q;
    assign posY        = pos_y_q;
    assign active      = active_q;
    assign frame_start = frame_start_q;
    assign locked      = locked_q;
    assign err         = err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Scoreboard bench for vga_sync_decoder on a shrunken raster (30 clk/line, 14 lines/frame).
module tb_vga_sync_decoder;

    localparam int HS  = 6;
    localparam int HA  = 16;
    localparam int VS  = 3;
    localparam int VA  = 8;
    localparam int LP  = 30;
    localparam int FL  = 14;
    localparam int HSW = 4;
    localparam int VSW = 2;
`ifdef VGA_DEC_STATS_EN
    localparam int EXP_LL = LP;
    localparam int EXP_FL = FL;
`else
    localparam int EXP_LL = 0;
    localparam int EXP_FL = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        Hsync_n = 1'b1;
    logic        Vsync_n = 1'b1;
    logic [2:0]  pixelIn = 3'd0;
    logic [2:0]  pixelOut;
    logic [10:0] posX, posY, lineLen, frameLines;
    logic        active, frame_start, locked, err;

    vga_sync_decoder #(
        .H_SYNC_TO_ACTIVE(HS),
        .H_ACTIVE        (HA),
        .V_SYNC_TO_ACTIVE(VS),
        .V_ACTIVE        (VA),
        .LOCK_FRAMES     (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .Hsync_n    (Hsync_n),
        .Vsync_n    (Vsync_n),
        .pixelIn    (pixelIn),
        .pixelOut   (pixelOut),
        .posX       (posX),
        .posY       (posY),
        .active     (active),
        .frame_start(frame_start),
        .locked     (locked),
        .err        (err),
        .lineLen    (lineLen),
        .frameLines (frameLines)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [28:0] vec;
    } sb_t;

    sb_t sb[$];
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    int  err_seen = 0;

    wire [28:0] obs      = {active, pixelOut, posX, posY, frame_start, locked, err};
    wire [50:0] all_outs = {pixelOut, posX, posY, active, frame_start, locked, err, lineLen, frameLines};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic drive(input logic hs, input logic vs, input logic [2:0] px,
                         input bit push, input logic [28:0] exp);
        sb_t ent;
        @(negedge clk);
        Hsync_n = hs;
        Vsync_n = vs;
        pixelIn = px;
        if (push) sb.push_back('{due: cyc + 2, vec: exp});
        @(posedge clk);
        #1;
        cyc++;
        if (err === 1'b1) err_seen++;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            ent = sb.pop_front();
            check_eq("pipe", {35'd0, obs}, {35'd0, ent.vec});
        end
    endtask

    task automatic reset_mid();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_async", {13'd0, all_outs}, 64'd0);
        @(posedge clk);
        #1;
        check_eq("rst_next", {13'd0, all_outs}, 64'd0);
        repeat (3) @(posedge clk);
        sb.delete();
        @(negedge clk);
        Hsync_n = 1'b1;
        Vsync_n = 1'b1;
        pixelIn = 3'd0;
        rst     = 1'b1;
    endtask

    // One frame; Vsync_n and Hsync_n fall together at line 0, cycle 0.
    task automatic run_frame(input int short_line, input int stretch_line, input int rst_line,
                             input bit chk, input logic lk);
        for (int l = 0; l < FL; l++) begin
            int len;
            len = LP;
            if (l == short_line)   len = LP - 1;
            if (l == stretch_line) len = LP + 2100;
            for (int c = 0; c < len; c++) begin
                int          hc;
                logic        win, act, fs;
                logic [2:0]  px, pe;
                logic [10:0] ex, ey;
                if (l == rst_line && c == HS + 10) begin
                    reset_mid();
                    return;
                end
                hc  = c - 2;
                win = (c >= 2) && (hc >= HS) && (hc < HS + HA) && (l >= VS) && (l < VS + VA);
                if (!win)                         px = 3'b111;
                else if (hc == HS && l == VS)     px = 3'b101;
                else                              px = 3'($urandom_range(0, 7));
                act = lk & win;
                pe  = act ? px : 3'd0;
                ex  = act ? 11'(hc - HS) : 11'd0;
                ey  = act ? 11'(l - VS) : 11'd0;
                fs  = (l == 0 && c == 0);
                drive((c < HSW) ? 1'b0 : 1'b1, (l < VSW) ? 1'b0 : 1'b1, px, chk,
                      {act, pe, ex, ey, fs, lk, 1'b0});
            end
        end
    endtask

    initial begin
        int e0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_state", {13'd0, all_outs}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        run_frame(-1, -1, -1, 1, 1'b0);
        run_frame(-1, -1, -1, 1, 1'b0);
        run_frame(-1, -1, -1, 1, 1'b1);
        run_frame(-1, -1, -1, 1, 1'b1);
        check_eq("locked_acq", {63'd0, locked}, 64'd1);
        check_eq("line_len", {53'd0, lineLen}, 64'(EXP_LL));
        check_eq("frame_lines", {53'd0, frameLines}, 64'(EXP_FL));

        e0 = err_seen;
        run_frame(5, -1, -1, 0, 1'b0);
        check_eq("err_short_cnt", 64'(err_seen - e0), 64'd1);
        check_eq("lock_drop_short", {63'd0, locked}, 64'd0);
        run_frame(-1, -1, -1, 1, 1'b0);
        run_frame(-1, -1, -1, 1, 1'b0);
        run_frame(-1, -1, -1, 1, 1'b1);
        check_eq("relock_short", {63'd0, locked}, 64'd1);

        e0 = err_seen;
        run_frame(-1, 4, -1, 0, 1'b0);
        check_eq("err_sat_cnt", 64'(err_seen - e0), 64'd1);
        check_eq("lock_drop_sat", {63'd0, locked}, 64'd0);
        run_frame(-1, -1, -1, 1, 1'b0);
        run_frame(-1, -1, -1, 1, 1'b0);
        run_frame(-1, -1, -1, 1, 1'b1);
        check_eq("relock_sat", {63'd0, locked}, 64'd1);

        run_frame(-1, -1, VS + 1, 1, 1'b1);
        run_frame(-1, -1, -1, 1, 1'b0);
        run_frame(-1, -1, -1, 1, 1'b0);
        run_frame(-1, -1, -1, 1, 1'b1);
        check_eq("relock_rst", {63'd0, locked}, 64'd1);
        drive(1'b1, 1'b1, 3'b111, 0, 29'd0);
        drive(1'b1, 1'b1, 3'b111, 0, 29'd0);
        check_eq("sb_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
